top_top_test: RTL and testbench

// - Top-level matrix engine: loads one 4x8 byte matrix X, multiplies it by a fixed 8x4 coefficient matrix C, and streams out the 4x4 product P.
// - Results pass through an internal 16x32 result RAM, then go out one word per cycle.
// - Matrices are processed back-to-back; the host starts the next matrix after finish.

---
 rtl/top_top_test.sv | 232 +++++++++++++++++++++++
 tb/tb_top_top_test.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_top_test.sv
// Matrix engine: loads a 4x8 byte matrix X, multiplies by the fixed 8x4 ROM C, streams out the 4x4 product.
// Build option: define SIGNED_X_EN to treat X bytes as two's-complement (sign-extended results).
module top_top_test #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 32,
    parameter int ROWS   = 4,
    parameter int INNER  = 8,
    parameter int COLS   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic              valid_input,
    input  logic [DATA_W-1:0] X_load,
    output logic              cs_n,
    output logic              ry,
    output logic [OUT_W-1:0]  read_data,
    output logic              finish
);

    localparam int N_X  = ROWS * INNER;
    localparam int N_P  = ROWS * COLS;
    localparam int N_C  = INNER * COLS;
    localparam int X_AW = $clog2(N_X);
    localparam int P_AW = $clog2(N_P);
    localparam int C_AW = $clog2(N_C);
    localparam int I_W  = $clog2(ROWS);
    localparam int J_W  = $clog2(COLS);
    localparam int K_W  = $clog2(INNER);

`ifdef SIGNED_X_EN
    localparam bit SIGNED_X = 1'b1;
    localparam int ACC_W    = 2 * DATA_W + $clog2(INNER) + 1;
`else
    localparam bit SIGNED_X = 1'b0;
    localparam int ACC_W    = 2 * DATA_W + $clog2(INNER);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_READ,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [X_AW-1:0]   r_ld_cnt;
    logic [DATA_W-1:0] r_x [N_X];
    logic [K_W-1:0]    r_k;
    logic [J_W-1:0]    r_j;
    logic [I_W-1:0]    r_i;
    logic [ACC_W-1:0]  r_acc;
    logic [P_AW-1:0]   r_rd_addr;
    logic [OUT_W-1:0]  r_ram [N_P];
    logic [OUT_W-1:0]  r_rd_data;
    logic              r_cs_n;
    logic              r_ry;
    logic              r_finish;

    logic                       w_load_fire;
    logic                       w_load_last;
    logic                       w_mac_last;
    logic                       w_rd_last;
    logic                       w_ram_we;
    logic [N_X-1:0]             w_x_we;
    logic [N_C-1:0][DATA_W-1:0] w_c_rom;
    logic [X_AW-1:0]            w_x_idx;
    logic [C_AW-1:0]            w_c_idx;
    logic [DATA_W-1:0]          w_x_sel;
    logic [DATA_W-1:0]          w_c_sel;
    logic [ACC_W-1:0]           w_x_ext;
    logic [ACC_W-1:0]           w_c_ext;
    logic [ACC_W-1:0]           w_prod;
    logic [ACC_W-1:0]           w_sum;
    logic [P_AW-1:0]            w_wr_addr;
    logic [OUT_W-1:0]           w_wr_data;
    logic                       w_cs_n_next;
    logic                       w_ry_next;
    logic                       w_finish_next;

    // Coefficient ROM: C[k][j] sits at flat index k*COLS+j and equals that index plus one.
    genvar gi;
    generate
        for (gi = 0; gi < N_C; gi++) begin : g_c_rom
            assign w_c_rom[gi] = DATA_W'(gi + 1);
        end
        for (gi = 0; gi < N_X; gi++) begin : g_x_we
            assign w_x_we[gi] = w_load_fire && (r_ld_cnt == X_AW'(gi));
        end
    endgenerate

    assign w_load_fire = (r_state == S_LOAD) && valid_input;
    assign w_load_last = w_load_fire && (r_ld_cnt == X_AW'(N_X - 1));
    assign w_mac_last  = (r_state == S_CALC) && (r_k == K_W'(INNER - 1))
                         && (r_j == J_W'(COLS - 1)) && (r_i == I_W'(ROWS - 1));
    assign w_rd_last   = (r_state == S_READ) && (r_rd_addr == P_AW'(N_P - 1));
    assign w_ram_we    = (r_state == S_CALC) && (r_k == K_W'(INNER - 1));

    // MAC datapath; modulo-2^ACC_W arithmetic keeps two's-complement results exact.
    assign w_x_idx   = X_AW'(int'(r_i) * INNER + int'(r_k));
    assign w_c_idx   = C_AW'(int'(r_k) * COLS + int'(r_j));
    assign w_x_sel   = r_x[w_x_idx];
    assign w_c_sel   = w_c_rom[w_c_idx];
    assign w_x_ext   = {{(ACC_W - DATA_W){SIGNED_X & w_x_sel[DATA_W-1]}}, w_x_sel};
    assign w_c_ext   = {{(ACC_W - DATA_W){1'b0}}, w_c_sel};
    assign w_prod    = w_x_ext * w_c_ext;
    assign w_sum     = ((r_k == '0) ? '0 : r_acc) + w_prod;
    assign w_wr_addr = P_AW'(int'(r_i) * COLS + int'(r_j));
    assign w_wr_data = {{(OUT_W - ACC_W){SIGNED_X & w_sum[ACC_W-1]}}, w_sum};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start_in)    w_state_next = S_LOAD;
            S_LOAD:  if (w_load_last) w_state_next = S_CALC;
            S_CALC:  if (w_mac_last)  w_state_next = S_READ;
            S_READ:  if (w_rd_last)   w_state_next = S_DONE;
            S_DONE:                   w_state_next = S_IDLE;
            default:                  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cs_n_next   = 1'b1;
        w_ry_next     = 1'b0;
        w_finish_next = 1'b0;
        case (r_state)
            S_READ: begin
                w_cs_n_next = 1'b0;
                w_ry_next   = 1'b1;
            end
            S_DONE:  w_finish_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < N_X; n++) begin
                r_x[n] <= '0;
            end
        end else begin
            for (int n = 0; n < N_X; n++) begin
                if (w_x_we[n]) begin
                    r_x[n] <= X_load;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ld_cnt  <= '0;
            r_k       <= '0;
            r_j       <= '0;
            r_i       <= '0;
            r_acc     <= '0;
            r_rd_addr <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_ld_cnt <= '0;
            end else if (w_load_fire) begin
                r_ld_cnt <= r_ld_cnt + 1'b1;
            end

            // k innermost, then j, then i; all wrap to zero after the last MAC.
            if (r_state == S_CALC) begin
                r_acc <= w_sum;
                if (r_k == K_W'(INNER - 1)) begin
                    r_k <= '0;
                    if (r_j == J_W'(COLS - 1)) begin
                        r_j <= '0;
                        r_i <= (r_i == I_W'(ROWS - 1)) ? '0 : r_i + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end else begin
                r_k <= '0;
                r_j <= '0;
                r_i <= '0;
            end

            if (r_state == S_READ) begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end else begin
                r_rd_addr <= '0;
            end
        end
    end

    // Result RAM: no reset so it maps onto block RAM; registered read.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_wr_addr] <= w_wr_data;
        end
        if (r_state == S_READ) begin
            r_rd_data <= r_ram[r_rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cs_n   <= 1'b1;
            r_ry     <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_cs_n   <= w_cs_n_next;
            r_ry     <= w_ry_next;
            r_finish <= w_finish_next;
        end
    end

    assign cs_n      = r_cs_n;
    assign ry        = r_ry;
    assign finish    = r_finish;
    assign read_data = r_ry ? r_rd_data : '0;

endmodule

// File: tb/tb_top_top_test.sv
// Self-checking bench for top_top_test: directed and random matrices against an arithmetic reference.
module tb_top_top_test;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_in = 1'b0;
    logic        valid_input = 1'b0;
    logic [7:0]  X_load = 8'd0;
    logic        cs_n;
    logic        ry;
    logic [31:0] read_data;
    logic        finish;

    top_top_test dut (
        .clk         (clk),
        .rst         (rst),
        .start_in    (start_in),
        .valid_input (valid_input),
        .X_load      (X_load),
        .cs_n        (cs_n),
        .ry          (ry),
        .read_data   (read_data),
        .finish      (finish)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  xm [32];
    logic [31:0] exp_w [16];
    logic [31:0] cap_w [16];
    int cap_n, first_ry, last_ry, fin_n, fin_cyc, cs_bad, zero_bad;
    bit timed_out;

    function automatic int xval(input logic [7:0] b);
`ifdef SIGNED_X_EN
        return int'($signed(b));
`else
        return int'(b);
`endif
    endfunction

    // Reference: P[i][j] = sum_k x[i][k] * (4k + j + 1), as a 32-bit two's-complement word.
    function automatic void model();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 8; k++) s += xval(xm[i*8+k]) * (4*k + j + 1);
                exp_w[i*4+j] = s;
            end
        end
    endfunction

    // Called at a falling edge; returns at the falling edge after the start edge.
    task automatic do_start();
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
    endtask

    // mode 0: gap-free, 1: gap before every byte, 2: random gaps.
    task automatic load(input int mode);
        for (int n = 0; n < 32; n++) begin
            if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) begin
                valid_input = 1'b0;
                X_load      = 8'($urandom);
                @(negedge clk);
            end
            valid_input = 1'b1;
            X_load      = xm[n];
            @(negedge clk);
        end
        valid_input = 1'b0;
        X_load      = 8'($urandom);
    endtask

    // Counts edges after the 32nd byte edge and records the output burst; optionally pulses start_in.
    task automatic collect(input int pulse_at);
        cap_n = 0; first_ry = -1; last_ry = -1; fin_n = 0; fin_cyc = -1;
        cs_bad = 0; zero_bad = 0; timed_out = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            start_in = (n == pulse_at);
            @(negedge clk);
            if (cs_n !== ~ry) cs_bad++;
            if (ry !== 1'b1 && read_data !== 32'd0) zero_bad++;
            if (ry === 1'b1) begin
                if (first_ry < 0) first_ry = n;
                if (cap_n < 16) cap_w[cap_n] = read_data;
                cap_n++;
                last_ry = n;
            end
            if (finish === 1'b1) begin
                fin_n++;
                fin_cyc   = n;
                timed_out = 1'b0;
                break;
            end
        end
        start_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
        total++; if (ry !== 1'b0) begin bad++; $display("FAIL reset_ry got %b want 0", ry); end
        total++; if (read_data !== 32'd0) begin bad++; $display("FAIL reset_read_data got %0h want 0", read_data); end
        total++; if (finish !== 1'b0) begin bad++; $display("FAIL reset_finish got %b want 0", finish); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (ry !== 1'b0 || cs_n !== 1'b1) begin bad++; $display("FAIL idle_outputs got ry=%b cs_n=%b want ry=0 cs_n=1", ry, cs_n); end
        $display("reset: outputs checked during and after reset");
    endtask

    task automatic test_ones();
        for (int n = 0; n < 32; n++) xm[n] = 8'd1;
        do_start(); load(0); collect(0);
        for (int w = 0; w < 16; w++) begin
            total++;
            if (cap_w[w] !== 32'(120 + 8*(w%4))) begin bad++; $display("FAIL ones_word%0d got %0d want %0d", w, cap_w[w], 120 + 8*(w%4)); end
        end
        total++; if (timed_out) begin bad++; $display("FAIL ones_timeout got no finish want finish"); end
        total++; if (first_ry !== 129) begin bad++; $display("FAIL ones_latency got %0d want 129", first_ry); end
        total++; if (cap_n !== 16 || last_ry - first_ry !== 15) begin bad++; $display("FAIL ones_burst got %0d words over %0d cycles want 16 over 16", cap_n, last_ry - first_ry + 1); end
        total++; if (fin_n !== 1 || fin_cyc !== last_ry + 1) begin bad++; $display("FAIL ones_finish got cycle %0d want %0d", fin_cyc, last_ry + 1); end
        total++; if (cs_bad !== 0 || zero_bad !== 0) begin bad++; $display("FAIL ones_strobes got cs_bad=%0d zero_bad=%0d want 0 0", cs_bad, zero_bad); end
        @(negedge clk);
        total++; if (finish !== 1'b0) begin bad++; $display("FAIL ones_finish_width got %b want 0", finish); end
        $display("ones: matrix done, first ry at %0d, %0d words", first_ry, cap_n);
    endtask

    task automatic test_identity();
        for (int n = 0; n < 32; n++) xm[n] = ((n % 8) == (n / 8)) ? 8'd1 : 8'd0;
        do_start(); load(0); collect(0);
        for (int w = 0; w < 16; w++) begin
            total++;
            if (cap_w[w] !== 32'(w + 1)) begin bad++; $display("FAIL identity_word%0d got %0d want %0d", w, cap_w[w], w + 1); end
        end
        total++; if (cap_n !== 16 || timed_out) begin bad++; $display("FAIL identity_burst got %0d words want 16", cap_n); end
        $display("identity: matrix done, %0d words", cap_n);
    endtask

    task automatic test_all_ff();
        logic [31:0] want;
        for (int n = 0; n < 32; n++) xm[n] = 8'hFF;
        do_start(); load(0); collect(0);
        for (int w = 0; w < 16; w++) begin
`ifdef SIGNED_X_EN
            want = -(120 + 8*(w%4));
`else
            want = 255 * (120 + 8*(w%4));
`endif
            total++;
            if (cap_w[w] !== want) begin bad++; $display("FAIL ff_word%0d got %0h want %0h", w, cap_w[w], want); end
        end
        total++; if (cap_n !== 16 || timed_out) begin bad++; $display("FAIL ff_burst got %0d words want 16", cap_n); end
        $display("all_ff: matrix done, %0d words", cap_n);
    endtask

    task automatic test_gapped();
        logic [31:0] ref_w [16];
        for (int n = 0; n < 32; n++) xm[n] = 8'($urandom);
        model();
        do_start(); load(0); collect(0);
        for (int w = 0; w < 16; w++) ref_w[w] = cap_w[w];
        do_start(); load(1); collect(20);
        for (int w = 0; w < 16; w++) begin
            total++;
            if (cap_w[w] !== exp_w[w] || cap_w[w] !== ref_w[w]) begin
                bad++; $display("FAIL gapped_word%0d got %0h (gap-free %0h) want %0h", w, cap_w[w], ref_w[w], exp_w[w]);
            end
        end
        total++; if (first_ry !== 129 || cap_n !== 16 || fin_n !== 1) begin bad++; $display("FAIL gapped_protocol got ry_at=%0d words=%0d finish=%0d want 129 16 1", first_ry, cap_n, fin_n); end
        repeat (5) @(negedge clk);
        total++; if (ry !== 1'b0) begin bad++; $display("FAIL gapped_no_restart got ry=%b want 0", ry); end
        $display("gapped: matrix done with start pulse during calc, %0d words", cap_n);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_a [16];
        logic [31:0] cap_a [16];
        int n_a;
        for (int n = 0; n < 32; n++) xm[n] = 8'($urandom);
        model();
        for (int w = 0; w < 16; w++) exp_a[w] = exp_w[w];
        do_start(); load(0); collect(0);
        for (int w = 0; w < 16; w++) cap_a[w] = cap_w[w];
        n_a = cap_n;
        for (int n = 0; n < 32; n++) xm[n] = 8'($urandom);
        model();
        do_start(); load(0); collect(0);
        for (int w = 0; w < 16; w++) begin
            total++;
            if (cap_a[w] !== exp_a[w]) begin bad++; $display("FAIL b2b_a_word%0d got %0h want %0h", w, cap_a[w], exp_a[w]); end
            total++;
            if (cap_w[w] !== exp_w[w]) begin bad++; $display("FAIL b2b_b_word%0d got %0h want %0h", w, cap_w[w], exp_w[w]); end
        end
        total++; if (n_a !== 16 || cap_n !== 16 || timed_out) begin bad++; $display("FAIL b2b_bursts got %0d and %0d words want 16 and 16", n_a, cap_n); end
        $display("back_to_back: two matrices done, %0d + %0d words", n_a, cap_n);
    endtask

    task automatic test_reset_mid_load();
        do_start();
        for (int n = 0; n < 10; n++) begin
            valid_input = 1'b1;
            X_load      = 8'($urandom);
            @(negedge clk);
        end
        valid_input = 1'b0;
        rst = 1'b0;
        #1;
        total++; if (cs_n !== 1'b1 || ry !== 1'b0 || finish !== 1'b0 || read_data !== 32'd0) begin
            bad++; $display("FAIL midload_reset got cs_n=%b ry=%b finish=%b data=%0h want 1 0 0 0", cs_n, ry, finish, read_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 32; n++) xm[n] = 8'($urandom);
        model();
        do_start(); load(0); collect(0);
        for (int w = 0; w < 16; w++) begin
            total++;
            if (cap_w[w] !== exp_w[w]) begin bad++; $display("FAIL midload_word%0d got %0h want %0h", w, cap_w[w], exp_w[w]); end
        end
        total++; if (first_ry !== 129 || cap_n !== 16) begin bad++; $display("FAIL midload_protocol got ry_at=%0d words=%0d want 129 16", first_ry, cap_n); end
        $display("reset_mid_load: fresh matrix done, %0d words", cap_n);
    endtask

    task automatic test_random();
        for (int t = 0; t < 3; t++) begin
            for (int n = 0; n < 32; n++) xm[n] = 8'($urandom);
            model();
            do_start(); load(2); collect(0);
            for (int w = 0; w < 16; w++) begin
                total++;
                if (cap_w[w] !== exp_w[w]) begin bad++; $display("FAIL random%0d_word%0d got %0h want %0h", t, w, cap_w[w], exp_w[w]); end
            end
            total++; if (first_ry !== 129 || cap_n !== 16 || fin_cyc !== last_ry + 1) begin
                bad++; $display("FAIL random%0d_protocol got ry_at=%0d words=%0d fin=%0d want 129 16 %0d", t, first_ry, cap_n, fin_cyc, last_ry + 1);
            end
            $display("random%0d: matrix done, %0d words", t, cap_n);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_identity();
        test_all_ff();
        test_gapped();
        test_back_to_back();
        test_reset_mid_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
